// File: rtl/lb_rr_dispatcher.sv
// rtl/lb_rr_dispatcher.sv - round-robin dispatch stage with per-offer stall timeout
// Holds one request and offers it to one backend at a time; a stalled backend is blocked and skipped.
module lb_rr_dispatcher #(
  parameter int N_OUT        = 4,
  parameter int DATA_W       = 64,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [N_OUT-1:0]         out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic [N_OUT-1:0]         out_ready,
  output logic [$clog2(N_OUT)-1:0] sel,
  output logic [N_OUT-1:0]         blocked,
  output logic                     timeout_pulse
);
  localparam int PTR_W = $clog2(N_OUT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_OUT - 1);
  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX = '1;

  logic                    held;
  logic [PTR_W-1:0]        ptr;
  logic [TIMEOUT_BITS-1:0] cnt;
  logic [DATA_W-1:0]       data_q;

  logic             hs, load, stall, timeout;
  logic [N_OUT-1:0] ptr_onehot, blk_set;
  logic [PTR_W-1:0] rot_ptr, cand;
  logic             found;

  assign ptr_onehot    = N_OUT'(1) << ptr;
  assign hs            = held && out_ready[ptr];
  assign stall         = held && !out_ready[ptr];
  assign timeout       = stall && (cnt == CNT_MAX);
  assign in_ready      = !reset && (!held || hs);
  assign load          = in_valid && in_ready;
  assign blk_set       = blocked | (timeout ? ptr_onehot : '0);

  assign out_valid     = held ? ptr_onehot : '0;
  assign out_data      = data_q;
  assign sel           = ptr;
  assign timeout_pulse = timeout;

  // Scan forward from ptr (ptr itself last) for the first channel not blocked after this cycle's set.
  always_comb begin
    rot_ptr = (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
    cand    = ptr;
    found   = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + PTR_W'(1);
      if (!found && !blk_set[cand]) begin
        found   = 1'b1;
        rot_ptr = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held    <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      blocked <= '0;
    end else begin
      if (load) begin
        held <= 1'b1;
      end else if (hs) begin
        held <= 1'b0;
      end

      if (hs || timeout) begin
        ptr <= rot_ptr;
      end

      if (load || hs || timeout) begin
        cnt <= '0;
      end else if (stall) begin
        cnt <= cnt + TIMEOUT_BITS'(1);
      end

      // A set needs out_ready[ptr]=0, so it never collides with a clear of the same bit.
      blocked <= blk_set & ~out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= in_data;
    end
  end
endmodule

// File: tb/tb_lb_rr_dispatcher.sv
// tb/tb_lb_rr_dispatcher.sv - self-checking bench for lb_rr_dispatcher
module tb_lb_rr_dispatcher;
  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int TB  = 4;
  localparam int MAX = (1 << TB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [N-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_ready = '0;
  logic [1:0]    sel;
  logic [N-1:0]  blocked;
  logic          timeout_pulse;

  int n_cmp = 0;
  int n_fail = 0;

  lb_rr_dispatcher #(.N_OUT(N), .DATA_W(DW), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .sel(sel),
    .blocked(blocked), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: one held slot, integer pointer, integer stall count.
  logic          m_held;
  logic [DW-1:0] m_data;
  int            m_ptr;
  int            m_cnt;
  logic [N-1:0]  m_blocked;

  function automatic int next_free(int p, logic [N-1:0] b);
    for (int k = 1; k <= N; k++) begin
      if (!b[(p + k) % N]) return (p + k) % N;
    end
    return (p + 1) % N;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic rdy, hs, ld, to;
    logic [N-1:0] bset;
    if (reset) begin
      m_held = 1'b0; m_ptr = 0; m_cnt = 0; m_blocked = '0;
    end else begin
      rdy  = out_ready[m_ptr];
      hs   = m_held && rdy;
      ld   = in_valid && (!m_held || hs);
      to   = m_held && !rdy && (m_cnt == MAX);
      bset = m_blocked;
      if (to) bset[m_ptr] = 1'b1;
      if (hs || to) m_ptr = next_free(m_ptr, bset);
      m_blocked = bset & ~out_ready;
      if (ld || hs || to) m_cnt = 0;
      else if (m_held && !rdy) m_cnt = m_cnt + 1;
      if (ld) begin
        m_held = 1'b1; m_data = in_data;
      end else if (hs) begin
        m_held = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic [N-1:0] r);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] x;
    x = {$urandom, $urandom};
    #1;
    n_cmp++; if (out_valid !== 4'b0000 || blocked !== 4'b0000 || sel !== 2'd0 || timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: ov=%b blk=%b sel=%0d tp=%b, need 0000/0000/0/0", out_valid, blocked, sel, timeout_pulse); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b need 1", in_ready); end
    cyc(1'b1, x, 4'b0000);
    cyc(1'b0, '0, 4'b0000);
    n_cmp++; if (out_valid !== 4'b0001 || out_data !== x) begin
      n_fail++; $display("FAIL mid_offer: ov=%b data=%h need 0001/%h", out_valid, out_data, x); end
    #2 reset = 1'b1; #1;
    n_cmp++; if (out_valid !== 4'b0000 || in_ready !== 1'b0 || sel !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: ov=%b ir=%b sel=%0d need 0000/0/0", out_valid, in_ready, sel); end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b need 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 4'b1111);
      n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL dropped_reappears: ov=%b need 0000", out_valid); end
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] d [5];
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom};
    for (int i = 0; i <= 5; i++) begin
      cyc(i < 5, (i < 5) ? d[i % 5] : '0, 4'b1111);
      n_cmp++; if (in_ready !== 1'b1 || timeout_pulse !== 1'b0) begin
        n_fail++; $display("FAIL rr_flow[%0d]: ir=%b tp=%b need 1/0", i, in_ready, timeout_pulse); end
      if (i > 0) begin
        exp = 4'(1 << ((i - 1) % N));
        n_cmp++; if (out_valid !== exp || out_data !== d[i - 1]) begin
          n_fail++; $display("FAIL rr_offer[%0d]: ov=%b data=%h need %b/%h", i, out_valid, out_data, exp, d[i - 1]); end
      end
    end
    cyc(1'b0, '0, 4'b1111);
    n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_drain: ov=%b need 0000", out_valid); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] x, y, z, w;
    x = {$urandom, $urandom}; y = {$urandom, $urandom}; z = {$urandom, $urandom}; w = {$urandom, $urandom};
    do_reset();
    cyc(1'b1, x, 4'b1110);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, '0, 4'b1110);
      n_cmp++; if (out_valid !== 4'b0001 || in_ready !== 1'b0 || out_data !== x || timeout_pulse !== (i == 16)) begin
        n_fail++; $display("FAIL to_stall[%0d]: ov=%b ir=%b tp=%b need 0001/0/%b", i, out_valid, in_ready, timeout_pulse, i == 16); end
    end
    cyc(1'b1, y, 4'b1110);
    n_cmp++; if (out_valid !== 4'b0010 || out_data !== x || blocked !== 4'b0001 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL to_reoffer: ov=%b data=%h blk=%b ir=%b need 0010/%h/0001/1", out_valid, out_data, blocked, in_ready, x); end
    cyc(1'b1, z, 4'b1110);
    n_cmp++; if (out_valid !== 4'b0100 || out_data !== y) begin
      n_fail++; $display("FAIL to_next_y: ov=%b data=%h need 0100/%h", out_valid, out_data, y); end
    cyc(1'b1, w, 4'b1110);
    n_cmp++; if (out_valid !== 4'b1000 || out_data !== z) begin
      n_fail++; $display("FAIL to_next_z: ov=%b data=%h need 1000/%h", out_valid, out_data, z); end
    cyc(1'b0, '0, 4'b1110);
    n_cmp++; if (out_valid !== 4'b0010 || out_data !== w || blocked !== 4'b0001) begin
      n_fail++; $display("FAIL to_skip0: ov=%b data=%h blk=%b need 0010/%h/0001", out_valid, out_data, blocked, w); end
  endtask

  task automatic test_unblock();
    logic [N-1:0] exp;
    cyc(1'b0, '0, 4'b0001);
    n_cmp++; if (blocked !== 4'b0001) begin n_fail++; $display("FAIL ub_before: blk=%b need 0001", blocked); end
    cyc(1'b0, '0, 4'b1111);
    n_cmp++; if (blocked !== 4'b0000 || sel !== 2'd2) begin
      n_fail++; $display("FAIL ub_cleared: blk=%b sel=%0d need 0000/2", blocked, sel); end
    for (int i = 0; i <= 4; i++) begin
      cyc(i < 4, DW'(i + 100), 4'b1111);
      if (i > 0) begin
        exp = 4'(1 << ((i + 1) % N));
        n_cmp++; if (out_valid !== exp || out_data !== DW'(i + 99)) begin
          n_fail++; $display("FAIL ub_rot[%0d]: ov=%b data=%h need %b/%h", i, out_valid, out_data, exp, DW'(i + 99)); end
      end
    end
  endtask

  task automatic test_race();
    do_reset();
    cyc(1'b1, 64'hA5A5, 4'b1110);
    for (int i = 1; i <= 15; i++) cyc(1'b0, '0, 4'b1110);
    cyc(1'b0, '0, 4'b1111);
    n_cmp++; if (timeout_pulse !== 1'b0 || out_valid !== 4'b0001 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL race_edge: tp=%b ov=%b ir=%b need 0/0001/1", timeout_pulse, out_valid, in_ready); end
    cyc(1'b0, '0, 4'b1111);
    n_cmp++; if (out_valid !== 4'b0000 || blocked !== 4'b0000 || sel !== 2'd1) begin
      n_fail++; $display("FAIL race_after: ov=%b blk=%b sel=%0d need 0000/0000/1", out_valid, blocked, sel); end
  endtask

  task automatic test_all_stalled();
    logic [DW-1:0] x;
    logic [N-1:0] exp;
    logic got;
    x = {$urandom, $urandom};
    do_reset();
    cyc(1'b1, x, 4'b0000);
    for (int t = 0; t < 4; t++) begin
      exp = 4'(1 << t);
      for (int i = 1; i <= 16; i++) begin
        cyc(1'b0, '0, 4'b0000);
        n_cmp++; if (out_valid !== exp || in_ready !== 1'b0 || timeout_pulse !== (i == 16)) begin
          n_fail++; $display("FAIL stall_all[%0d.%0d]: ov=%b ir=%b tp=%b need %b/0/%b", t, i, out_valid, in_ready, timeout_pulse, exp, i == 16); end
      end
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(1'b0, '0, 4'b0100);
      if (i == 0) begin
        n_cmp++; if (blocked !== 4'b1111 || sel !== 2'd0) begin
          n_fail++; $display("FAIL stall_all_blk: blk=%b sel=%0d need 1111/0", blocked, sel); end
      end
      if (out_valid[2]) begin
        got = 1'b1;
        n_cmp++; if (out_data !== x || in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stall_all_deliver: data=%h ir=%b need %h/1", out_data, in_ready, x); end
      end
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL stall_all_wait: channel 2 never offered within 40 cycles"); end
    cyc(1'b0, '0, 4'b0000);
    n_cmp++; if (blocked[2] !== 1'b0 || out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL stall_all_after: blk=%b ov=%b need bit2=0/0000", blocked, out_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] stuck, exp_ov;
    logic exp_ir, exp_tp;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) stuck = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, 4'($urandom) & ~stuck);
      exp_ov = m_held ? 4'(1 << m_ptr) : 4'b0000;
      exp_ir = !m_held || out_ready[m_ptr];
      exp_tp = m_held && !out_ready[m_ptr] && (m_cnt == MAX);
      n_cmp++; if (out_valid !== exp_ov || in_ready !== exp_ir || timeout_pulse !== exp_tp) begin
        n_fail++; $display("FAIL rand_hs[%0d]: ov=%b ir=%b tp=%b need %b/%b/%b", c, out_valid, in_ready, timeout_pulse, exp_ov, exp_ir, exp_tp); end
      n_cmp++; if (sel !== 2'(m_ptr) || blocked !== m_blocked) begin
        n_fail++; $display("FAIL rand_state[%0d]: sel=%0d blk=%b need %0d/%b", c, sel, blocked, m_ptr, m_blocked); end
      if (m_held) begin
        n_cmp++; if (out_data !== m_data) begin
          n_fail++; $display("FAIL rand_data[%0d]: got %h need %h", c, out_data, m_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_unblock();
    test_race();
    test_all_stalled();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/lb_rr_dispatcher.md
# lb_rr_dispatcher

- Round-robin dispatch stage of the load balancer: accepts one request per cycle on a valid/ready input and offers it to one of N_OUT backend channels.
- Each offer is guarded by a saturating stall timer. A channel that stalls for too long is marked blocked and skipped, and the held request moves to the next channel.
- Sits directly downstream of the request ingress and directly upstream of the per-backend queues.

## Interface
Parameters:
- N_OUT, 4: number of backend channels (≥2)
- DATA_W, 64: request width
- TIMEOUT_BITS, 4: stall timer width; MAX = 2**TIMEOUT_BITS-1

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  one clock; reset is asynchronous and active-high
- in_valid  in  1  request valid
- in_data  in  DATA_W  request payload
- in_ready  out  1  stage can take a request
- out_valid  out  N_OUT  one-hot offer; bit i = offered to channel i
- out_data  out  DATA_W  held request, shared by all channels
- out_ready  in  N_OUT  per-channel accept
- sel  out  $clog2(N_OUT)  current round-robin pointer
- blocked  out  N_OUT  channel marked stalled
- timeout_pulse  out  1  one-cycle pulse on each timeout

## Operation
State:
- held: 1-entry output register flag
- ptr: round-robin pointer
- cnt: stall timer, TIMEOUT_BITS bits
- blocked: N_OUT flags

Output and handshake rules:
- out_valid = held ? onehot(ptr) : 0.
- out_data = register contents; value undefined when held=0.
- hs (output handshake) = held && out_ready[ptr].
- in_ready = !reset && (!held || hs). This allows back-to-back flow.
- Input handshake (in_valid && in_ready) loads out_data and sets held.
- hs without a new load clears held.

Stall timer:
- cnt clears to 0 on: load, hs, rotation.
- Otherwise, while held && !out_ready[ptr]:
  - cnt < MAX: cnt increments.
  - cnt == MAX: timeout.

Timeout:
- Set blocked[ptr].
- Pulse timeout_pulse.
- Rotate ptr.
- The request stays held and is offered to the new ptr next cycle; an offer is revocable only on timeout.

Rotation target:
- First index after ptr (wrapping) whose blocked bit is 0, using blocked values that include any bit set this cycle.
- If all channels are blocked: ptr+1 mod N_OUT.

Pointer advance:
- ptr advances by the rotation rule on every hs and every timeout.
- ptr does not change otherwise.

Unblocking:
- blocked[i] clears on any cycle out_ready[i]=1, whether or not channel i is offered.

Simultaneous events:
- hs and cnt==MAX in the same cycle: hs wins; no timeout, no blocked set.
- A set and a clear of blocked[i] cannot coincide, because a set requires out_ready[ptr]=0.

Reset:
- Asynchronous assert clears all state immediately; a held request is dropped.

## Timing
- Reset values: held=0, ptr=0, sel=0, cnt=0, blocked=0, out_valid=0, timeout_pulse=0, in_ready=0 while reset is high; in_ready=1 first cycle after release.
- Latency: input handshake at edge t gives out_valid at cycle t+1.
- Throughput: 1 request/cycle while the targeted channels accept.
- Timeout: fires on the (MAX+1)th consecutive stalled cycle on one channel (16 cycles for TIMEOUT_BITS=4). The new channel is offered the cycle after.
- While held with no hs, in_ready=0, including every cycle of a timeout/rotation sequence.
- sel is a registered copy of ptr; no combinational path from out_ready to sel.

## Test plan
- Reset: assert reset mid-offer → out_valid=0, blocked=0, sel=0, in_ready=0 during reset, 1 one cycle after release; dropped request never reappears.
- Round robin: out_ready=4'b1111, push A..E back-to-back → A..E on channels 0,1,2,3,0 at t+1..t+5, in_ready stays 1, no timeouts.
- Timeout: out_ready[0]=0, others 1, push X → out_valid=0001 for 16 cycles, timeout_pulse on the 16th, blocked=0001, X accepted on channel 1 next cycle; next pushes go to channels 2,3,1 (0 skipped).
- Unblock: after the timeout test, pulse out_ready[0] for one cycle → blocked[0]=0 next edge; subsequent rotation includes channel 0.
- Race: out_ready[ptr] rises on the 16th stall cycle → handshake, no timeout_pulse, blocked unchanged, ptr advances.
- All stalled: out_ready=0, push X → timeouts every 16 cycles, ptr 0→1→2→3→0, blocked=1111, in_ready=0 throughout; raise out_ready[2] → X delivered on channel 2 when it is offered, blocked[2] clears.
